// File: rtl/adbg_jsp_fifo_shifter.sv
// JTAG Serial Port data path: up/dn byte FIFOs plus the count-header DR shifter,
// all in the TCK domain.
module adbg_jsp_fifo_shifter #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                tck_i,
    input  logic                                rst_i,
    input  logic                                tdi_i,
    output logic                                module_tdo_o,
    input  logic                                capture_dr_i,
    input  logic                                shift_dr_i,
    input  logic                                update_dr_i,
    input  logic                                module_select_i,
    input  logic [7:0]                          up_data_i,
    input  logic                                up_valid_i,
    output logic                                up_ready_o,
    output logic [7:0]                          dn_data_o,
    output logic                                dn_valid_o,
    input  logic                                dn_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     up_count_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     dn_count_o
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned HW    = 2 * CNT_W;
    localparam int unsigned SW    = (HW > 8) ? HW : 8;
    localparam int unsigned BCW   = $clog2(SW);

    typedef enum logic [1:0] {StIdle, StHdr, StData, StDone} state_e;

    state_e             state_q, state_d;
    logic [SW-1:0]      out_sr_q, out_sr_d;
    logic [HW-2:0]      hdr_sr_q, hdr_sr_d;
    logic [6:0]         in_sr_q, in_sr_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   slot_q, slot_d;
    logic [CNT_W-1:0]   su_q, su_d, sf_q, sf_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    // Pointers carry one extra wrap bit so occupancy is simply wptr - rptr.
    logic [CNT_W-1:0]   up_wptr_q, up_wptr_d, up_rptr_q, up_rptr_d;
    logic [CNT_W-1:0]   dn_wptr_q, dn_wptr_d, dn_rptr_q, dn_rptr_d;
    logic [7:0]         up_mem_q [FIFO_DEPTH];
    logic [7:0]         dn_mem_q [FIFO_DEPTH];

    logic               up_push, up_pop, dn_push, dn_pop;
    logic [HW-1:0]      hdr_full;
    logic [CNT_W-1:0]   n_rd, n_wr, rd_new, wr_new, max_cnt, slot_nx;
    logic [7:0]         in_byte, up_head;

    assign up_count_o   = up_wptr_q - up_rptr_q;
    assign dn_count_o   = dn_wptr_q - dn_rptr_q;
    assign up_ready_o   = (up_count_o != CNT_W'(FIFO_DEPTH));
    assign dn_valid_o   = (dn_count_o != '0);
    assign dn_data_o    = dn_valid_o ? dn_mem_q[dn_rptr_q[AW-1:0]] : 8'h00;
    assign module_tdo_o = (state_q == StDone) ? 1'b0 : out_sr_q[0];

    // Header/byte assembly includes the bit currently on tdi_i.
    assign hdr_full = {tdi_i, hdr_sr_q};
    assign n_rd     = hdr_full[CNT_W-1:0];
    assign n_wr     = hdr_full[HW-1:CNT_W];
    assign rd_new   = (n_rd < su_q) ? n_rd : su_q;
    assign wr_new   = (n_wr < sf_q) ? n_wr : sf_q;
    assign in_byte  = {tdi_i, in_sr_q};
    assign up_head  = up_mem_q[up_rptr_q[AW-1:0]];
    assign max_cnt  = (rd_cnt_q > wr_cnt_q) ? rd_cnt_q : wr_cnt_q;
    assign slot_nx  = slot_q + CNT_W'(1);

    // Next-state: scan FSM, shift registers and FIFO pointers.
    always_comb begin
        state_d   = state_q;
        out_sr_d  = out_sr_q;
        hdr_sr_d  = hdr_sr_q;
        in_sr_d   = in_sr_q;
        bit_cnt_d = bit_cnt_q;
        slot_d    = slot_q;
        su_d      = su_q;
        sf_d      = sf_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        up_push   = up_valid_i & up_ready_o;
        dn_pop    = dn_valid_o & dn_ready_i;
        up_pop    = 1'b0;
        dn_push   = 1'b0;
        if (module_select_i) begin
            if (capture_dr_i) begin
                su_d      = up_count_o;
                sf_d      = CNT_W'(FIFO_DEPTH) - dn_count_o;
                out_sr_d  = SW'({sf_d, su_d});
                bit_cnt_d = '0;
                state_d   = StHdr;
            end else if (update_dr_i) begin
                state_d = StIdle;
            end else if (shift_dr_i) begin
                case (state_q)
                    StHdr: begin
                        out_sr_d  = out_sr_q >> 1;
                        hdr_sr_d  = hdr_full[HW-1:1];
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        if (bit_cnt_q == BCW'(HW - 1)) begin
                            rd_cnt_d  = rd_new;
                            wr_cnt_d  = wr_new;
                            slot_d    = '0;
                            bit_cnt_d = '0;
                            if (rd_new != '0 || wr_new != '0) begin
                                state_d = StData;
                                if (rd_new != '0) begin
                                    out_sr_d = SW'(up_head);
                                    up_pop   = 1'b1;
                                end else begin
                                    out_sr_d = '0;
                                end
                            end else begin
                                state_d = StDone;
                            end
                        end
                    end
                    StData: begin
                        out_sr_d  = out_sr_q >> 1;
                        in_sr_d   = in_byte[7:1];
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        if (bit_cnt_q == BCW'(7)) begin
                            bit_cnt_d = '0;
                            dn_push   = (slot_q < wr_cnt_q);
                            slot_d    = slot_nx;
                            if (slot_nx >= max_cnt) begin
                                state_d = StDone;
                            end else if (slot_nx < rd_cnt_q) begin
                                out_sr_d = SW'(up_head);
                                up_pop   = 1'b1;
                            end else begin
                                out_sr_d = '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
        up_wptr_d = up_wptr_q + CNT_W'(up_push);
        up_rptr_d = up_rptr_q + CNT_W'(up_pop);
        dn_wptr_d = dn_wptr_q + CNT_W'(dn_push);
        dn_rptr_d = dn_rptr_q + CNT_W'(dn_pop);
    end

    // State and pointer registers.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            out_sr_q  <= '0;
            hdr_sr_q  <= '0;
            in_sr_q   <= '0;
            bit_cnt_q <= '0;
            slot_q    <= '0;
            su_q      <= '0;
            sf_q      <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            up_wptr_q <= '0;
            up_rptr_q <= '0;
            dn_wptr_q <= '0;
            dn_rptr_q <= '0;
        end else begin
            state_q   <= state_d;
            out_sr_q  <= out_sr_d;
            hdr_sr_q  <= hdr_sr_d;
            in_sr_q   <= in_sr_d;
            bit_cnt_q <= bit_cnt_d;
            slot_q    <= slot_d;
            su_q      <= su_d;
            sf_q      <= sf_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            up_wptr_q <= up_wptr_d;
            up_rptr_q <= up_rptr_d;
            dn_wptr_q <= dn_wptr_d;
            dn_rptr_q <= dn_rptr_d;
        end
    end

    // FIFO storage; cleared on reset so the dn head reads zero.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            up_mem_q <= '{default: 8'h00};
            dn_mem_q <= '{default: 8'h00};
        end else begin
            if (up_push) up_mem_q[up_wptr_q[AW-1:0]] <= up_data_i;
            if (dn_push) dn_mem_q[dn_wptr_q[AW-1:0]] <= in_byte;
        end
    end

endmodule

// File: tb/tb_adbg_jsp_fifo_shifter.sv
// Directed bench for the JSP FIFO shifter: table of scans plus corner sequences.
module tb_adbg_jsp_fifo_shifter;
    logic       tck_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       tdi_i = 1'b0;
    logic       module_tdo_o;
    logic       capture_dr_i = 1'b0;
    logic       shift_dr_i = 1'b0;
    logic       update_dr_i = 1'b0;
    logic       module_select_i = 1'b0;
    logic [7:0] up_data_i = 8'h00;
    logic       up_valid_i = 1'b0;
    logic       up_ready_o;
    logic [7:0] dn_data_o;
    logic       dn_valid_o;
    logic       dn_ready_i = 1'b0;
    logic [3:0] up_count_o;
    logic [3:0] dn_count_o;

    int checks = 0;
    int errors = 0;

    adbg_jsp_fifo_shifter #(.FIFO_DEPTH(8)) dut (
        .tck_i           (tck_i),
        .rst_i           (rst_i),
        .tdi_i           (tdi_i),
        .module_tdo_o    (module_tdo_o),
        .capture_dr_i    (capture_dr_i),
        .shift_dr_i      (shift_dr_i),
        .update_dr_i     (update_dr_i),
        .module_select_i (module_select_i),
        .up_data_i       (up_data_i),
        .up_valid_i      (up_valid_i),
        .up_ready_o      (up_ready_o),
        .dn_data_o       (dn_data_o),
        .dn_valid_o      (dn_valid_o),
        .dn_ready_i      (dn_ready_i),
        .up_count_o      (up_count_o),
        .dn_count_o      (dn_count_o)
    );

    always #5 tck_i = ~tck_i;

    typedef struct {
        int          n_push;
        logic [23:0] push;
        logic [3:0]  n_rd;
        logic [3:0]  n_wr;
        int          nslots;
        logic [63:0] din;
        logic [7:0]  exp_hdr;
        logic [63:0] exp_dout;
        logic [3:0]  exp_up;
        logic [3:0]  exp_dn;
        int          n_pop;
        logic [63:0] exp_pop;
    } vec_t;

    vec_t vecs [6];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    task automatic cyc();
        @(posedge tck_i);
        #1;
    endtask

    task automatic push_up(input logic [7:0] b);
        up_data_i  = b;
        up_valid_i = 1'b1;
        cyc();
        up_valid_i = 1'b0;
    endtask

    task automatic pop_dn();
        dn_ready_i = 1'b1;
        cyc();
        dn_ready_i = 1'b0;
    endtask

    task automatic capture();
        capture_dr_i = 1'b1;
        cyc();
        capture_dr_i = 1'b0;
    endtask

    task automatic update();
        update_dr_i = 1'b1;
        cyc();
        update_dr_i = 1'b0;
    endtask

    // TDO is sampled before each shift edge, TDI driven for that edge.
    task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        shift_dr_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            tdi_i   = din[i];
            dout[i] = module_tdo_o;
            cyc();
        end
        shift_dr_i = 1'b0;
        tdi_i = 1'b0;
    endtask

    task automatic scan(input logic [3:0] nrd, input logic [3:0] nwr, input int nslots,
                        input logic [63:0] din, output logic [7:0] hdr,
                        output logic [63:0] dout);
        logic [63:0] h;
        module_select_i = 1'b1;
        capture();
        shift_bits(8, {56'h0, nwr, nrd}, h);
        hdr = h[7:0];
        shift_bits(nslots * 8, din, dout);
        update();
    endtask

    initial begin
        logic [7:0]  hdr;
        logic [63:0] dout;
        logic [63:0] ta;
        logic [63:0] tb;
        logic [63:0] junk;

        vecs[0] = '{0, 24'h0, 4'd0, 4'd0, 0, 64'h0, 8'h80, 64'h0, 4'd0, 4'd0, 0, 64'h0};
        vecs[1] = '{3, 24'hC3B2A1, 4'd5, 4'd0, 4, 64'h0, 8'h83, 64'h00C3B2A1, 4'd0, 4'd0,
                    0, 64'h0};
        vecs[2] = '{0, 24'h0, 4'd0, 4'd2, 2, 64'hAA55, 8'h80, 64'h0, 4'd0, 4'd2, 0, 64'h0};
        vecs[3] = '{2, 24'h0201, 4'd2, 4'd2, 2, 64'hBC9A, 8'h62, 64'h0201, 4'd0, 4'd4,
                    4, 64'hBC9AAA55};
        vecs[4] = '{0, 24'h0, 4'd0, 4'd7, 7, 64'h07060504030201, 8'h80, 64'h0, 4'd0, 4'd7,
                    0, 64'h0};
        vecs[5] = '{0, 24'h0, 4'd0, 4'd4, 4, 64'h44332211, 8'h10, 64'h0, 4'd0, 4'd8,
                    8, 64'h1107060504030201};

        // Reset values while reset is held.
        #2;
        chk("rst_tdo", 64'(module_tdo_o), 64'h0);
        chk("rst_up_ready", 64'(up_ready_o), 64'h1);
        chk("rst_dn_valid", 64'(dn_valid_o), 64'h0);
        chk("rst_dn_data", 64'(dn_data_o), 64'h0);
        chk("rst_up_count", 64'(up_count_o), 64'h0);
        chk("rst_dn_count", 64'(dn_count_o), 64'h0);
        cyc();
        rst_i = 1'b0;
        cyc();

        for (int v = 0; v < 6; v++) begin
            for (int p = 0; p < vecs[v].n_push; p++) push_up(vecs[v].push[p*8 +: 8]);
            scan(vecs[v].n_rd, vecs[v].n_wr, vecs[v].nslots, vecs[v].din, hdr, dout);
            chk($sformatf("v%0d_hdr", v), 64'(hdr), 64'(vecs[v].exp_hdr));
            chk($sformatf("v%0d_dout", v), dout, vecs[v].exp_dout);
            chk($sformatf("v%0d_up_count", v), 64'(up_count_o), 64'(vecs[v].exp_up));
            chk($sformatf("v%0d_dn_count", v), 64'(dn_count_o), 64'(vecs[v].exp_dn));
            chk($sformatf("v%0d_up_ready", v), 64'(up_ready_o), 64'h1);
            for (int p = 0; p < vecs[v].n_pop; p++) begin
                chk($sformatf("v%0d_pop%0d_valid", v, p), 64'(dn_valid_o), 64'h1);
                chk($sformatf("v%0d_pop%0d_data", v, p), 64'(dn_data_o),
                    64'(vecs[v].exp_pop[p*8 +: 8]));
                pop_dn();
            end
            if (vecs[v].n_pop > 0) begin
                chk($sformatf("v%0d_drained_valid", v), 64'(dn_valid_o), 64'h0);
                chk($sformatf("v%0d_drained_count", v), 64'(dn_count_o), 64'h0);
            end
        end

        // Target push while the scan is popping the same FIFO.
        push_up(8'h01);
        push_up(8'h02);
        fork
            scan(4'd2, 4'd0, 2, 64'h0, hdr, dout);
            begin
                repeat (12) @(posedge tck_i);
                #1;
                push_up(8'h77);
            end
        join
        chk("cc_hdr", 64'(hdr), 64'h82);
        chk("cc_dout", dout, 64'h0201);
        chk("cc_up_count", 64'(up_count_o), 64'h1);
        scan(4'd1, 4'd0, 1, 64'h0, hdr, dout);
        chk("cc2_hdr", 64'(hdr), 64'h81);
        chk("cc2_dout", dout, 64'h77);

        // Up FIFO full: ninth push ignored, request of 15 clamped to 8.
        for (int i = 0; i < 9; i++) push_up(8'h10 + 8'(i));
        chk("full_count", 64'(up_count_o), 64'h8);
        chk("full_ready", 64'(up_ready_o), 64'h0);
        scan(4'd15, 4'd0, 8, 64'h0, hdr, dout);
        chk("full_hdr", 64'(hdr), 64'h88);
        chk("full_dout", dout, 64'h1716151413121110);
        chk("full_after_count", 64'(up_count_o), 64'h0);

        // Reset in the middle of slot 1.
        push_up(8'hA1);
        push_up(8'hB2);
        push_up(8'hC3);
        capture();
        shift_bits(8, 64'h05, junk);
        shift_bits(11, 64'h0, ta);
        chk("mid_up_count", 64'(up_count_o), 64'h1);
        chk("mid_slot0_byte", 64'(ta[7:0]), 64'hA1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_tdo", 64'(module_tdo_o), 64'h0);
        chk("mid_rst_up_count", 64'(up_count_o), 64'h0);
        chk("mid_rst_dn_count", 64'(dn_count_o), 64'h0);
        cyc();
        rst_i = 1'b0;
        cyc();
        scan(4'd0, 4'd0, 0, 64'h0, hdr, dout);
        chk("post_rst_hdr", 64'(hdr), 64'h80);

        // Deselect mid-header: shifts and capture ignored, scan resumes intact.
        push_up(8'h01);
        capture();
        shift_bits(3, 64'h01, ta);
        module_select_i = 1'b0;
        shift_bits(20, '1, junk);
        capture();
        update();
        chk("desel_up_count", 64'(up_count_o), 64'h1);
        module_select_i = 1'b1;
        shift_bits(13, 64'h0, tb);
        update();
        chk("desel_tdo", {48'h0, tb[12:0], ta[2:0]}, 64'h0181);
        chk("desel_after_count", 64'(up_count_o), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
